sweep_cfg_sequencer: RTL and testbench

//  Accepts one sweep request (freq_l/freq_u MHz, sweep_span ns), computes AD9914 DRG params

---
 rtl/sweep_cfg_pkg.sv | 40 ++++
 rtl/sweep_cfg_sequencer_div.sv | 59 +++++
 rtl/sweep_cfg_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_sweep_cfg_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_cfg_pkg.sv
// Shared types and constants for the AD9914 sweep configuration sequencer.
package sweep_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DIV_FTWL,
    S_DIV_FTWU,
    S_DIV_STEP,
    S_DIV_RATE,
    S_WR_LO,
    S_WR_HI,
    S_WR_PSTEP,
    S_WR_NSTEP,
    S_WR_RATE,
    S_IOUPD,
    S_RANGE_ERR,
    S_DONE
  } seq_state_t;

  localparam logic [7:0] ADDR_DRG_LOWER = 8'h04;
  localparam logic [7:0] ADDR_DRG_UPPER = 8'h05;
  localparam logic [7:0] ADDR_DRG_PSTEP = 8'h06;
  localparam logic [7:0] ADDR_DRG_NSTEP = 8'h07;
  localparam logic [7:0] ADDR_DRG_RATE  = 8'h08;

  localparam logic [15:0] RATE_MAX = 16'hFFFF;
  localparam logic [15:0] RATE_MIN = 16'h0001;

  // A zero rate would stall the ramp, so it is clamped up to one.
  function automatic logic [15:0] saturate_rate(input logic [63:0] q);
    if (q > 64'(RATE_MAX)) begin
      return RATE_MAX;
    end else if (q == 64'd0) begin
      return RATE_MIN;
    end else begin
      return q[15:0];
    end
  endfunction

endpackage

// File: rtl/sweep_cfg_sequencer_div.sv
// seq_divider_64: 64/64 unsigned restoring divider, one quotient bit per clock.
// A zero divisor yields an all-ones quotient.
module seq_divider_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        done,
  output logic [63:0] quotient
);

  logic [63:0] quo_q;
  logic [63:0] den_q;
  logic [63:0] rem_q;
  logic [63:0] rem_sub;
  logic [64:0] rem_shift;
  logic        ge;
  logic [5:0]  cnt_q;
  logic        run_q;

  // The true difference always fits in 64 bits when ge is set.
  always_comb begin
    rem_shift = {rem_q, quo_q[63]};
    rem_sub   = rem_shift[63:0] - den_q;
    ge        = rem_shift[64] | (rem_shift[63:0] >= den_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo_q <= dividend;
        den_q <= divisor;
        rem_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        quo_q <= {quo_q[62:0], ge};
        rem_q <= ge ? rem_sub : rem_shift[63:0];
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/sweep_cfg_sequencer.sv
// Computes AD9914 DRG parameters with one shared divider, writes them out, then pulses io_update.
// Optional RANGE_CHECK_EN macro rejects requests with freq_l>=freq_u or 2*freq_u>REF.
module sweep_cfg_sequencer
  import sweep_cfg_pkg::*;
#(
  parameter int unsigned AD9914_REF_FREQ = 3480,
  parameter int unsigned SWEEP_STEP_NUM  = 100,
  parameter int unsigned RATE_DIV        = 24000,
  parameter int unsigned IOUPD_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] freq_l,
  input  logic [31:0] freq_u,
  input  logic [31:0] sweep_span,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        io_update,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [31:0] ftw_l,
  output logic [31:0] ftw_u,
  output logic [31:0] positive_step,
  output logic [15:0] positive_rate
);

  localparam int CW = $clog2(IOUPD_CYCLES + 1);
  localparam logic [CW-1:0] UPD_LAST = CW'(IOUPD_CYCLES - 1);

  seq_state_t  state_q, state_d;
  logic        ready_q;
  logic [31:0] fl_q, fu_q, span_q;
  logic [CW-1:0] upd_cnt_q;
  logic        div_launched_q;
  logic        div_start;
  logic        div_done;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic [63:0] div_quotient;
  logic        accept;

  assign accept = cfg_valid && cfg_ready;

`ifdef RANGE_CHECK_EN
  logic range_bad;
  logic cfg_err_q;
  assign range_bad = (freq_l >= freq_u) || ({freq_u, 1'b0} > 33'(AD9914_REF_FREQ));
  assign cfg_err   = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    io_update = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef RANGE_CHECK_EN
          state_d = range_bad ? S_RANGE_ERR : S_DIV_FTWL;
`else
          state_d = S_DIV_FTWL;
`endif
        end
      end
      S_DIV_FTWL: begin
        div_start = !div_launched_q;
        if (div_done) state_d = S_DIV_FTWU;
      end
      S_DIV_FTWU: begin
        div_start = !div_launched_q;
        if (div_done) state_d = S_DIV_STEP;
      end
      S_DIV_STEP: begin
        div_start = !div_launched_q;
        if (div_done) state_d = S_DIV_RATE;
      end
      S_DIV_RATE: begin
        div_start = !div_launched_q;
        if (div_done) state_d = S_WR_LO;
      end
      S_WR_LO: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DRG_LOWER;
        wr_data = ftw_l;
        if (wr_ack) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DRG_UPPER;
        wr_data = ftw_u;
        if (wr_ack) state_d = S_WR_PSTEP;
      end
      S_WR_PSTEP: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DRG_PSTEP;
        wr_data = positive_step;
        if (wr_ack) state_d = S_WR_NSTEP;
      end
      S_WR_NSTEP: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DRG_NSTEP;
        wr_data = positive_step;
        if (wr_ack) state_d = S_WR_RATE;
      end
      S_WR_RATE: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_DRG_RATE;
        wr_data = {positive_rate, positive_rate};
        if (wr_ack) state_d = S_IOUPD;
      end
      S_IOUPD: begin
        io_update = 1'b1;
        if (upd_cnt_q == UPD_LAST) state_d = S_DONE;
      end
      S_RANGE_ERR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cfg_ready = ready_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  // Operands are captured by the divider on div_start, so they only need to be valid then.
  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    unique case (state_q)
      S_DIV_FTWL: begin
        div_dividend = {fl_q, 32'h0};
        div_divisor  = 64'(AD9914_REF_FREQ);
      end
      S_DIV_FTWU: begin
        div_dividend = {fu_q, 32'h0};
        div_divisor  = 64'(AD9914_REF_FREQ);
      end
      S_DIV_STEP: begin
        div_dividend = {32'h0, ftw_u - ftw_l};
        div_divisor  = 64'(SWEEP_STEP_NUM);
      end
      S_DIV_RATE: begin
        div_dividend = 64'(span_q) * 64'(AD9914_REF_FREQ);
        div_divisor  = 64'(SWEEP_STEP_NUM) * 64'(RATE_DIV);
      end
      default: begin
        div_dividend = '0;
        div_divisor  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q        <= 1'b0;
      fl_q           <= '0;
      fu_q           <= '0;
      span_q         <= '0;
      upd_cnt_q      <= '0;
      div_launched_q <= 1'b0;
      ftw_l          <= '0;
      ftw_u          <= '0;
      positive_step  <= '0;
      positive_rate  <= '0;
`ifdef RANGE_CHECK_EN
      cfg_err_q      <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        fl_q   <= freq_l;
        fu_q   <= freq_u;
        span_q <= sweep_span;
`ifdef RANGE_CHECK_EN
        cfg_err_q <= range_bad;
`endif
      end
      if (div_start) begin
        div_launched_q <= 1'b1;
      end else if (div_done) begin
        div_launched_q <= 1'b0;
      end
      if (div_done) begin
        unique case (state_q)
          S_DIV_FTWL: ftw_l         <= div_quotient[31:0];
          S_DIV_FTWU: ftw_u         <= div_quotient[31:0];
          S_DIV_STEP: positive_step <= div_quotient[31:0];
          S_DIV_RATE: positive_rate <= saturate_rate(div_quotient);
          default: ;
        endcase
      end
      upd_cnt_q <= (state_q == S_IOUPD) ? upd_cnt_q + CW'(1) : '0;
    end
  end

  seq_divider_64 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

endmodule

// File: tb/tb_sweep_cfg_sequencer.sv
// Scoreboard bench for sweep_cfg_sequencer; define RANGE_CHECK_EN to exercise the range-check build.
module tb_sweep_cfg_sequencer;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] ftw_l;
    logic [31:0] ftw_u;
    logic [31:0] step;
    logic [15:0] rate;
    logic        err;
    int          io_cycles;
    int          latency;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] freq_l = '0;
  logic [31:0] freq_u = '0;
  logic [31:0] sweep_span = '0;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        io_update;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] ftw_l;
  logic [31:0] ftw_u;
  logic [31:0] positive_step;
  logic [15:0] positive_rate;

  int n_compared = 0;
  int n_mismatch = 0;
  int cyc = 0;
  int accept_cyc = 0;
  wr_t  exp_wr_q[$];
  res_t exp_res_q[$];

  sweep_cfg_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .freq_l        (freq_l),
    .freq_u        (freq_u),
    .sweep_span    (sweep_span),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .io_update     (io_update),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .ftw_l         (ftw_l),
    .ftw_u         (ftw_u),
    .positive_step (positive_step),
    .positive_rate (positive_rate)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic res_t mk(input logic [31:0] fl, input logic [31:0] fu, input logic [31:0] st,
                              input logic [15:0] rt, input logic er, input int io, input int lat);
    res_t r;
    r.ftw_l = fl; r.ftw_u = fu; r.step = st; r.rate = rt;
    r.err = er; r.io_cycles = io; r.latency = lat;
    return r;
  endfunction

  // Write-master model: acks each request after a random 0..20 cycle delay.
  initial begin
    int wait_cnt;
    wait_cnt = $urandom_range(0, 20);
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        wr_ack = 1'b0;
      end else if (wr_ack) begin
        wr_ack = 1'b0;
        wait_cnt = $urandom_range(0, 20);
      end else if (wr_req) begin
        if (wait_cnt == 0) wr_ack = 1'b1;
        else wait_cnt--;
      end
    end
  end

  // Monitor: pops expected writes on each handshake and expected results on each done.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;
    int          io_cnt;
    wr_t         w;
    res_t        r;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_data = '0; io_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        io_cnt = 0;
      end else begin
        if (wr_req && prev_req && !prev_ack) begin
          checkOutput("wr_addr_stable", 64'(wr_addr), 64'(prev_addr));
          checkOutput("wr_data_stable", 64'(wr_data), 64'(prev_data));
        end
        if (wr_req && wr_ack) begin
          if (exp_wr_q.size() > 0) begin
            w = exp_wr_q.pop_front();
            checkOutput("wr_addr", 64'(wr_addr), 64'(w.addr));
            checkOutput("wr_data", 64'(wr_data), 64'(w.data));
          end else begin
            checkOutput("wr_expected", 64'(exp_wr_q.size()), 64'd1);
          end
        end
        if (io_update) io_cnt++;
        if (cfg_valid && cfg_ready) accept_cyc = cyc;
        if (done) begin
          if (exp_res_q.size() > 0) begin
            r = exp_res_q.pop_front();
            checkOutput("ftw_l", 64'(ftw_l), 64'(r.ftw_l));
            checkOutput("ftw_u", 64'(ftw_u), 64'(r.ftw_u));
            checkOutput("positive_step", 64'(positive_step), 64'(r.step));
            checkOutput("positive_rate", 64'(positive_rate), 64'(r.rate));
            checkOutput("cfg_err", 64'(cfg_err), 64'(r.err));
            checkOutput("io_update_cycles", 64'(io_cnt), 64'(r.io_cycles));
            checkOutput("writes_drained", 64'(exp_wr_q.size()), 64'd0);
            checkOutput("busy_at_done", 64'(busy), 64'd0);
            if (r.latency >= 0)
              checkOutput("done_latency", 64'(cyc - accept_cyc), 64'(r.latency));
          end else begin
            checkOutput("done_expected", 64'(exp_res_q.size()), 64'd1);
          end
          io_cnt = 0;
        end
        prev_req = wr_req; prev_ack = wr_ack; prev_addr = wr_addr; prev_data = wr_data;
      end
    end
  end

  task automatic pushWrites(input res_t r);
    exp_wr_q.push_back(wr_t'{8'h04, r.ftw_l});
    exp_wr_q.push_back(wr_t'{8'h05, r.ftw_u});
    exp_wr_q.push_back(wr_t'{8'h06, r.step});
    exp_wr_q.push_back(wr_t'{8'h07, r.step});
    exp_wr_q.push_back(wr_t'{8'h08, {r.rate, r.rate}});
  endtask

  task automatic issueRequest(input logic [31:0] fl, input logic [31:0] fu, input logic [31:0] span);
    int k;
    k = 0;
    while (!cfg_ready && k < 100) begin
      tick();
      k++;
    end
    checkOutput("cfg_ready_before_req", 64'(cfg_ready), 64'd1);
    freq_l = fl; freq_u = fu; sweep_span = span;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    freq_l = $urandom(); freq_u = $urandom(); sweep_span = $urandom();
  endtask

  task automatic applyStimulus(input logic [31:0] fl, input logic [31:0] fu, input logic [31:0] span,
                               input res_t r, input bit pester);
    bit seen;
    if (r.io_cycles > 0) pushWrites(r);
    exp_res_q.push_back(r);
    issueRequest(fl, fu, span);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      cfg_valid = pester && busy && (k % 5 == 0);
      if (cfg_valid) begin
        freq_l = $urandom_range(1, 500); freq_u = $urandom_range(600, 1700);
        sweep_span = $urandom();
      end
      tick();
    end
    cfg_valid = 1'b0;
    checkOutput("done_seen", 64'(seen), 64'd1);
    tick();
  endtask

  task automatic applyAbort();
    bit found;
    pushWrites(mk(32'd123418600, 32'd246837200, 32'd1234186, 16'd1450, 1'b0, 4, -1));
    issueRequest(32'd100, 32'd200, 32'd1_000_000);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (wr_req && wr_addr == 8'h06) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("reached_wr_pstep", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_wr_req", 64'(wr_req), 64'd0);
    checkOutput("abort_io_update", 64'(io_update), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("abort_ftw_l", 64'(ftw_l), 64'd0);
    exp_wr_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("abort_ready_again", 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    res_t base, r_sat, r_min, r_wide;
    base   = mk(32'd123418600, 32'd246837200, 32'd1234186, 16'd1450, 1'b0, 4, -1);
    r_sat  = mk(32'd123418600, 32'd246837200, 32'd1234186, 16'hFFFF, 1'b0, 4, -1);
    r_min  = mk(32'd123418600, 32'd246837200, 32'd1234186, 16'd1, 1'b0, 4, -1);
    r_wide = mk(32'd0, 32'd1234186004, 32'd12341860, 16'd7250, 1'b0, 4, -1);

    #12;
    checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
    checkOutput("rst_io_update", 64'(io_update), 64'd0);
    checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
    checkOutput("rst_results", {ftw_l, ftw_u} | 64'({positive_step, positive_rate}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("ready_after_reset", 64'(cfg_ready), 64'd1);

    $display("[TB] nominal sweep");
    applyStimulus(32'd100, 32'd200, 32'd1_000_000, base, 1'b0);
    $display("[TB] saturating rate with cfg_valid pulsed while busy");
    applyStimulus(32'd100, 32'd200, 32'd100_000_000, r_sat, 1'b1);
    $display("[TB] rate clamp to one");
    applyStimulus(32'd100, 32'd200, 32'd10, r_min, 1'b0);
    $display("[TB] wide sweep from zero");
    applyStimulus(32'd0, 32'd1000, 32'd5_000_000, r_wide, 1'b0);
`ifdef RANGE_CHECK_EN
    $display("[TB] rejected request, then a valid one");
    applyStimulus(32'd200, 32'd100, 32'd1_000_000,
                  mk(32'd0, 32'd1234186004, 32'd12341860, 16'd7250, 1'b1, 0, 2), 1'b0);
    applyStimulus(32'd100, 32'd200, 32'd1_000_000, base, 1'b0);
`else
    $display("[TB] inverted limits, step wraps");
    applyStimulus(32'd200, 32'd100, 32'd1_000_000,
                  mk(32'd246837200, 32'd123418600, 32'd41715486, 16'd1450, 1'b0, 4, -1), 1'b0);
`endif
    $display("[TB] reset during positive step write");
    applyAbort();
    applyStimulus(32'd100, 32'd200, 32'd1_000_000, base, 1'b0);

    repeat (10) tick();
    checkOutput("final_res_queue", 64'(exp_res_q.size()), 64'd0);
    checkOutput("final_wr_queue", 64'(exp_wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
